mos6502s_regfile: RTL

MOS6502S_REGFILE -- requirements
Module: mos6502s_regfile

---
 rtl/mos6502s_regfile.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mos6502s_regfile.sv
// 6502-style A/X/Y/SP register file: one prioritized operation per cycle, registered N/Z flags.
// Optional shadow snapshot/restore bank, enabled by defining MOS6502S_REGFILE_SHADOW_EN.
module mos6502s_regfile #(
    parameter int          WIDTH    = 8,
    parameter int unsigned SP_RESET = 32'hFD
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MOS6502S_REGFILE_SHADOW_EN
    input  logic             snap,
    input  logic             restore,
`endif
    input  logic             wr_en,
    input  logic [1:0]       wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             xfer_en,
    input  logic [1:0]       xfer_src,
    input  logic [1:0]       xfer_dst,
    input  logic             inc_en,
    input  logic             dec_en,
    input  logic [1:0]       id_sel,
    input  logic             sp_push,
    input  logic             sp_pop,
    input  logic [1:0]       rd0_sel,
    input  logic [1:0]       rd1_sel,
    output logic [WIDTH-1:0] rd0_data,
    output logic [WIDTH-1:0] rd1_data,
    output logic [WIDTH+7:0] stack_addr,
    output logic             n_flag,
    output logic             z_flag,
    output logic             nz_valid,
    output logic             op_err
);
    localparam logic [1:0]       SEL_SP  = 2'd3;
    localparam logic [WIDTH-1:0] SP_INIT = WIDTH'(SP_RESET);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] regs_q [4];
    logic [WIDTH-1:0] regs_d [4];
    logic             n_q, n_d;
    logic             z_q, z_d;
    logic             nz_valid_q, nz_valid_d;
    logic             op_err_q, op_err_d;
    logic [2:0]       op_cnt;
    logic             nz_upd;
    logic [1:0]       nz_tgt;
    logic [WIDTH-1:0] nz_res;
    logic             pop_exec;
    logic [WIDTH-1:0] sp_eff;
`ifdef MOS6502S_REGFILE_SHADOW_EN
    logic [WIDTH-1:0] shadow_q [4];
    logic [WIDTH-1:0] shadow_d [4];
`endif

    always_comb begin
        op_cnt = {2'b0, wr_en} + {2'b0, xfer_en} + {2'b0, inc_en}
               + {2'b0, dec_en} + {2'b0, sp_push} + {2'b0, sp_pop};
        op_err_d = (op_cnt > 3'd1);
    end

    // Single prioritized operation; conflicting inc/dec or push/pop pairs do nothing.
    always_comb begin
        regs_d   = regs_q;
        nz_upd   = 1'b0;
        nz_tgt   = 2'd0;
        nz_res   = '0;
        pop_exec = 1'b0;
`ifdef MOS6502S_REGFILE_SHADOW_EN
        if (restore) begin
            regs_d = shadow_q;
            nz_upd = 1'b1;
            nz_tgt = 2'd0;
            nz_res = shadow_q[0];
        end else
`endif
        if (wr_en) begin
            regs_d[wr_sel] = wr_data;
            nz_upd         = 1'b1;
            nz_tgt         = wr_sel;
            nz_res         = wr_data;
        end else if (xfer_en) begin
            regs_d[xfer_dst] = regs_q[xfer_src];
            nz_upd           = 1'b1;
            nz_tgt           = xfer_dst;
            nz_res           = regs_q[xfer_src];
        end else if (inc_en || dec_en) begin
            if (inc_en != dec_en) begin
                nz_res         = inc_en ? regs_q[id_sel] + ONE : regs_q[id_sel] - ONE;
                regs_d[id_sel] = nz_res;
                nz_upd         = 1'b1;
                nz_tgt         = id_sel;
            end
        end else if (sp_push != sp_pop) begin
            regs_d[SEL_SP] = sp_push ? regs_q[SEL_SP] - ONE : regs_q[SEL_SP] + ONE;
            pop_exec       = sp_pop;
        end
    end

    always_comb begin
        n_d        = n_q;
        z_d        = z_q;
        nz_valid_d = 1'b0;
        if (nz_upd && (nz_tgt != SEL_SP)) begin
            n_d        = nz_res[WIDTH-1];
            z_d        = (nz_res == '0);
            nz_valid_d = 1'b1;
        end
    end

`ifdef MOS6502S_REGFILE_SHADOW_EN
    always_comb begin
        shadow_d = shadow_q;
        if (snap && !restore) begin
            shadow_d = regs_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q[0] <= '0;
            shadow_q[1] <= '0;
            shadow_q[2] <= '0;
            shadow_q[3] <= SP_INIT;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q[0]  <= '0;
            regs_q[1]  <= '0;
            regs_q[2]  <= '0;
            regs_q[3]  <= SP_INIT;
            n_q        <= 1'b0;
            z_q        <= 1'b0;
            nz_valid_q <= 1'b0;
            op_err_q   <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            n_q        <= n_d;
            z_q        <= z_d;
            nz_valid_q <= nz_valid_d;
            op_err_q   <= op_err_d;
        end
    end

    // Pop reads the slot above the current SP before the increment lands.
    assign sp_eff     = pop_exec ? regs_q[SEL_SP] + ONE : regs_q[SEL_SP];
    assign stack_addr = {8'h01, sp_eff};
    assign rd0_data   = regs_q[rd0_sel];
    assign rd1_data   = regs_q[rd1_sel];
    assign n_flag     = n_q;
    assign z_flag     = z_q;
    assign nz_valid   = nz_valid_q;
    assign op_err     = op_err_q;

endmodule
